// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage RV32I pipeline.
// Generates PC / IF-ID / ID-EX stop and clear controls, EX operand
// forwarding selects, the ebreak drain-then-halt sequence and saturating
// stall / flush event counters. Only the FSM state, the drain counter and
// the event counters are registered. Every control output is combinational,
// so it acts in the cycle its cause appears.
// Handshake note: there is no valid/ready pair here. Controls are level
// signals that the pipeline registers sample at every rising edge.
module hazard_ctrl #(
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs0,
  input  logic [4:0]       id_rs1,
  input  logic             id_use0,
  input  logic             id_use1,
  input  logic [4:0]       ex_rs0,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_nop,
  input  logic             ex_ebreak,
  input  logic             ex_busy,
  input  logic             br_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             mem_nop,
  input  logic             wb_reg_write,
  input  logic             wb_nop,
  input  logic             resume,
  output logic             pc_stop,
  output logic             if_id_stop,
  output logic             if_id_clr,
  output logic             id_ex_stop,
  output logic             id_ex_clr,
  output logic [1:0]       fwd0,
  output logic [1:0]       fwd1,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  localparam int DW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             stall_inc, flush_inc;

  // A stage forwards only when it really writes a non-zero register.
  logic mem_ok, wb_ok, lu;
  assign mem_ok = mem_reg_write & ~mem_nop & (mem_rd != 5'd0);
  assign wb_ok  = wb_reg_write  & ~wb_nop  & (wb_rd  != 5'd0);

  // MEM is younger than WB, so its result wins when both match.
  assign fwd0 = !rst_n ? 2'b00 :
                (mem_ok && mem_rd == ex_rs0) ? 2'b01 :
                (wb_ok  && wb_rd  == ex_rs0) ? 2'b10 : 2'b00;
  assign fwd1 = !rst_n ? 2'b00 :
                (mem_ok && mem_rd == ex_rs1) ? 2'b01 :
                (wb_ok  && wb_rd  == ex_rs1) ? 2'b10 : 2'b00;

  // Load in EX whose result the ID instruction needs: the value is not
  // available for forwarding until the load reaches WB.
  assign lu = ex_reg_write & ex_mem_to_reg & ~ex_nop & (ex_rd != 5'd0) &
              id_valid & ((id_use0 & (id_rs0 == ex_rd)) |
                          (id_use1 & (id_rs1 == ex_rd)));

  // Next-state and pipeline controls. Reset overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    pc_stop    = 1'b0;
    if_id_stop = 1'b0;
    if_id_clr  = 1'b0;
    id_ex_stop = 1'b0;
    id_ex_clr  = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ex_ebreak && !ex_nop && !ex_busy) begin
          pc_stop   = 1'b1;
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
          state_d   = ST_DRAIN;
          dcnt_d    = DW'(DRAIN_CYC);
        end else if (ex_busy) begin
          pc_stop    = 1'b1;
          if_id_stop = 1'b1;
          id_ex_stop = 1'b1;
          stall_inc  = 1'b1;
        end else if (br_taken) begin
          if_id_clr = 1'b1;
          id_ex_clr = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          pc_stop    = 1'b1;
          if_id_stop = 1'b1;
          id_ex_clr  = 1'b1;
          stall_inc  = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_stop   = 1'b1;
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        if (dcnt_q <= DW'(1)) state_d = ST_HALTED;
        if (dcnt_q != '0) dcnt_d = dcnt_q - DW'(1);
      end
      ST_HALTED: begin
        halted     = 1'b1;
        pc_stop    = 1'b1;
        if_id_stop = 1'b1;
        id_ex_stop = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) begin
      pc_stop    = 1'b0;
      if_id_stop = 1'b0;
      id_ex_stop = 1'b0;
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      halted     = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    if (flush_inc && flush_q != '1) flush_d = flush_q + CNT_W'(1);
  end

  // State, drain counter and event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      dcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign dbg_state = state_q;

endmodule
